// File: rtl/traffic_seq_param.sv
// traffic_seq_param: traffic-light sequencer with a programmable dwell time per phase,
// a latched pedestrian request with walk/ack, an amber-flash fault mode and a clock enable.
// All outputs are registered. The next state is computed combinationally and captured in one register block.
module traffic_seq_param #(
    parameter int CNT_W       = 8,
    parameter int T_RED       = 8,
    parameter int T_RED_AMBER = 2,
    parameter int T_GREEN     = 8,
    parameter int T_AMBER     = 3,
    parameter int T_PED       = 4,
    parameter int FLASH_HALF  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ped_req,
    input  logic       flash,
    output logic       red,
    output logic       amber,
    output logic       green,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [2:0] PH_RED       = 3'd0;
    localparam logic [2:0] PH_RED_AMBER = 3'd1;
    localparam logic [2:0] PH_GREEN     = 3'd2;
    localparam logic [2:0] PH_AMBER     = 3'd3;
    localparam logic [2:0] PH_FLASH     = 3'd4;

    // Last counter value of each dwell; a serviced pedestrian request stretches RED by T_PED.
    localparam logic [CNT_W-1:0] RED_LAST       = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] RED_PED_LAST   = CNT_W'(T_RED + T_PED - 1);
    localparam logic [CNT_W-1:0] RED_AMBER_LAST = CNT_W'(T_RED_AMBER - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST     = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] AMBER_LAST     = CNT_W'(T_AMBER - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST     = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] blink_cnt, blink_cnt_n;
    logic             blink_on, blink_on_n;
    logic             ped_pending, ped_pending_n;
    logic [2:0]       phase_n;
    logic             walk_n, ped_ack_n;
    logic             red_n, amber_n, green_n;
    logic             enter_red;
    logic [CNT_W-1:0] red_last;

    // RED ends later when it is the walk phase of a serviced request.
    assign red_last = walk ? RED_PED_LAST : RED_LAST;

    // Next-state logic: flash takes priority over normal sequencing; entering RED services a pending request.
    always_comb begin
        phase_n       = phase;
        cnt_n         = cnt;
        blink_cnt_n   = blink_cnt;
        blink_on_n    = blink_on;
        walk_n        = walk;
        ped_ack_n     = 1'b0;
        ped_pending_n = ped_pending | ped_req;
        enter_red     = 1'b0;

        if (flash) begin
            if (phase != PH_FLASH) begin
                phase_n     = PH_FLASH;
                cnt_n       = '0;
                blink_cnt_n = '0;
                blink_on_n  = 1'b1;
                walk_n      = 1'b0;
            end else if (en) begin
                if (blink_cnt == FLASH_LAST) begin
                    blink_cnt_n = '0;
                    blink_on_n  = ~blink_on;
                end else begin
                    blink_cnt_n = blink_cnt + CNT_ONE;
                end
            end
        end else begin
            case (phase)
                PH_FLASH: enter_red = 1'b1;
                PH_RED: begin
                    if (en) begin
                        if (cnt == red_last) begin
                            phase_n = PH_RED_AMBER;
                            cnt_n   = '0;
                            walk_n  = 1'b0;
                        end else begin
                            cnt_n = cnt + CNT_ONE;
                        end
                    end
                end
                PH_RED_AMBER: begin
                    if (en) begin
                        if (cnt == RED_AMBER_LAST) begin
                            phase_n = PH_GREEN;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CNT_ONE;
                        end
                    end
                end
                PH_GREEN: begin
                    if (en) begin
                        if (cnt == GREEN_LAST) begin
                            phase_n = PH_AMBER;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CNT_ONE;
                        end
                    end
                end
                PH_AMBER: begin
                    if (en) begin
                        if (cnt == AMBER_LAST) begin
                            enter_red = 1'b1;
                        end else begin
                            cnt_n = cnt + CNT_ONE;
                        end
                    end
                end
                default: enter_red = 1'b1;
            endcase

            if (enter_red) begin
                phase_n     = PH_RED;
                cnt_n       = '0;
                blink_cnt_n = '0;
                if (ped_pending) begin
                    walk_n        = 1'b1;
                    ped_ack_n     = 1'b1;
                    ped_pending_n = ped_req;
                end else begin
                    walk_n = 1'b0;
                end
            end
        end

        red_n   = (phase_n == PH_RED) || (phase_n == PH_RED_AMBER);
        amber_n = (phase_n == PH_RED_AMBER) || (phase_n == PH_AMBER) ||
                  ((phase_n == PH_FLASH) && blink_on_n);
        green_n = (phase_n == PH_GREEN);
    end

    // State and output registers, forced to the RED rest state while reset is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase       <= PH_RED;
            cnt         <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b0;
            ped_pending <= 1'b0;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
            red         <= 1'b1;
            amber       <= 1'b0;
            green       <= 1'b0;
        end else begin
            phase       <= phase_n;
            cnt         <= cnt_n;
            blink_cnt   <= blink_cnt_n;
            blink_on    <= blink_on_n;
            ped_pending <= ped_pending_n;
            walk        <= walk_n;
            ped_ack     <= ped_ack_n;
            red         <= red_n;
            amber       <= amber_n;
            green       <= green_n;
        end
    end

endmodule
